gelato_warp_scheduler: RTL and testbench
========================================

# gelato_warp_scheduler

Per-SM warp issue scheduler sitting between the per-warp instruction buffers and the dispatch/operand stage. Each cycle it picks one eligible warp by round-robin, pops that warp's head instruction from its buffer, and holds it in a registered issue slot until dispatch accepts it. It also sequences warp-wide barriers: a barrier instruction parks its warp until every active warp has reached the barrier.

## Interface
Parameters:
- WARP_NUM, default `WARP_NUM` (4): number of warps / instruction buffers.
- INST_W, default 64: width of one decoded instruction.

Ports:
- clk  in  1  core clock; all state on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; 0 freezes all state, forces ibuf_caught=0.
- ibuf_valid  in  WARP_NUM  bit i: buffer i non-empty.
- ibuf_inst  in  WARP_NUM*INST_W  head instruction of buffer i (slice i).
- ibuf_barrier  in  WARP_NUM  bit i: head of buffer i is a barrier.
- ibuf_caught  out  WARP_NUM  one-hot pop; buffer i pops on the edge where bit i=1.
- warp_active  in  WARP_NUM  warp i launched and not finished.
- warp_stall  in  WARP_NUM  scoreboard hazard on warp i's head instruction.
- issue_valid  out  1  issue slot holds an instruction.
- issue_warp  out  $clog2(WARP_NUM)  warp id of issue slot.
- issue_inst  out  INST_W  instruction in issue slot.
- issue_ready  in  1  dispatch accepts issue slot this cycle.
- bar_wait  out  WARP_NUM  bit i: warp i parked at barrier.

## Operation
- eligible[i] = warp_active[i] & ibuf_valid[i] & ~warp_stall[i] & ~bar_wait[i].
- load = rdy & (~issue_valid | issue_ready).
- Round-robin: search from (last+1) mod WARP_NUM upward with wrap; first eligible i is the pick. last updated to pick only when a pick is taken.
- When load & any eligible: ibuf_caught[pick]=1 (combinational, same cycle).
  - ibuf_barrier[pick]=0: issue slot <= {1, pick, ibuf_inst[pick]}.
  - ibuf_barrier[pick]=1: barrier consumed, not sent downstream; bar_wait[pick]<=1; issue slot cleared to valid=0 if issue_ready, else held.
- When load & no eligible: issue_valid<=0 (if it was accepted).
- When ~load: issue slot holds; issue_warp/issue_inst stable while issue_valid & ~issue_ready.
- Barrier release: if (bar_wait | ~warp_active) == all-ones and bar_wait != 0, all bar_wait bits clear on the next edge (evaluated on registered bar_wait, gated by rdy).
- warp_active[i]=0 clears bar_wait[i] on the next edge (rdy=1).
- Per-warp state: RUN (bar_wait=0) -> WAIT on barrier pick; WAIT -> RUN on release or deactivation.

## Timing
- Reset (rst_n=0, async): issue_valid=0, issue_warp=0, issue_inst=0, bar_wait=0, last=WARP_NUM-1 (warp 0 wins first), ibuf_caught=0.
- Latency: buffer head eligible in cycle N -> ibuf_caught in N, issue_valid=1 from N+1.
- Throughput: one issue per cycle with issue_ready held 1.
- Simultaneous pick of warp i's barrier and release condition: release uses pre-edge bar_wait; warp i enters WAIT and is not released in that edge.
- Reset mid-operation discards the issue slot; no ibuf_caught is generated during reset.
- rdy=0: no pops, no slot update, no release, pointer held.

## Test plan
- Warps 0-3 valid, active, no stall, issue_ready=1 -> caught sequence 0,1,2,3,0; issue_warp lags caught by one cycle.
- Warp 1 stalled, warps 0,2 valid -> order 0,2,0,2; unstall warp 1 after last=0 -> next pick 1.
- issue_valid=1, issue_ready=0 for 3 cycles -> ibuf_caught=0, issue_inst/issue_warp stable; ready=1 -> new pick same cycle.
- Warps 0-3 active; barriers arrive on 0,2,1 -> bar_wait=0b0111, others blocked; warp 3 barrier -> bar_wait=0b1111 then 0 next cycle, issue_valid never set for barriers.
- Warps 0,1 waiting at barrier, warp 2 deactivates, warp 3 inactive, warp 2 never arrives -> release the cycle after warp_active[2]=0.
- rst_n asserted while issue_valid=1 and bar_wait=0b0011 -> all outputs zero immediately; after release warp 0 picked first.

Source files
------------

// File: rtl/gelato_warp_scheduler_if.sv
// Handshake bundle between the warp instruction buffers, the issue scheduler and dispatch.
// master = scheduler side, slave = buffers/scoreboard/dispatch side.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

interface gelato_warp_scheduler_if #(
   parameter int unsigned WARP_NUM = `WARP_NUM,
   parameter int unsigned INST_W   = 64
);
   localparam int unsigned WID_W = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;

   logic [WARP_NUM-1:0]        ibuf_valid;
   logic [WARP_NUM*INST_W-1:0] ibuf_inst;
   logic [WARP_NUM-1:0]        ibuf_barrier;
   logic [WARP_NUM-1:0]        ibuf_caught;
   logic [WARP_NUM-1:0]        warp_active;
   logic [WARP_NUM-1:0]        warp_stall;
   logic                       issue_valid;
   logic [WID_W-1:0]           issue_warp;
   logic [INST_W-1:0]          issue_inst;
   logic                       issue_ready;
   logic [WARP_NUM-1:0]        bar_wait;

   modport master (
      input  ibuf_valid, ibuf_inst, ibuf_barrier, warp_active, warp_stall, issue_ready,
      output ibuf_caught, issue_valid, issue_warp, issue_inst, bar_wait
   );

   modport slave (
      output ibuf_valid, ibuf_inst, ibuf_barrier, warp_active, warp_stall, issue_ready,
      input  ibuf_caught, issue_valid, issue_warp, issue_inst, bar_wait
   );
endinterface

// File: rtl/gelato_warp_scheduler.sv
// Round-robin warp issue scheduler with a registered issue slot and warp-wide barrier parking.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

module gelato_warp_scheduler #(
   parameter int unsigned WARP_NUM = `WARP_NUM,
   parameter int unsigned INST_W   = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rdy,
   gelato_warp_scheduler_if.master bus
);
   localparam int unsigned WID_W = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;

   typedef enum logic {WarpRun, WarpWait} warp_st_e;

   warp_st_e st_q [WARP_NUM];
   warp_st_e st_d [WARP_NUM];

   logic                issue_valid_q, issue_valid_d;
   logic [WID_W-1:0]    issue_warp_q, issue_warp_d;
   logic [INST_W-1:0]   issue_inst_q, issue_inst_d;
   logic [WID_W-1:0]    last_q, last_d;

   logic [WARP_NUM-1:0] bar_wait;
   logic [WARP_NUM-1:0] eligible;
   logic [WARP_NUM-1:0] caught;
   logic [WID_W-1:0]    pick;
   logic [WID_W-1:0]    cand;
   logic                found;
   logic                load;
   logic                take_bar;
   logic                bar_release;

   always_comb begin
      bar_wait = '0;
      for (int unsigned i = 0; i < WARP_NUM; i++) begin
         bar_wait[i] = (st_q[i] == WarpWait);
      end
   end

   assign eligible = bus.warp_active & bus.ibuf_valid & ~bus.warp_stall & ~bar_wait;
   assign load     = rdy & (~issue_valid_q | bus.issue_ready);

   // Every live warp parked (inactive ones don't count) releases the whole group.
   assign bar_release = (|bar_wait) & (&(bar_wait | ~bus.warp_active));

   // Search starts one past the last winner and wraps.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= WARP_NUM; k++) begin
         cand = WID_W'((32'(last_q) + k) % WARP_NUM);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_warp_d  = issue_warp_q;
      issue_inst_d  = issue_inst_q;
      last_d        = last_q;
      caught        = '0;
      take_bar      = 1'b0;
      if (load) begin
         if (found) begin
            caught[pick] = 1'b1;
            last_d       = pick;
            if (bus.ibuf_barrier[pick]) begin
               // Barriers are consumed here and never reach dispatch.
               take_bar      = 1'b1;
               issue_valid_d = 1'b0;
            end else begin
               issue_valid_d = 1'b1;
               issue_warp_d  = pick;
               issue_inst_d  = bus.ibuf_inst[32'(pick)*INST_W +: INST_W];
            end
         end else begin
            issue_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < WARP_NUM; i++) begin
         st_d[i] = st_q[i];
         if (rdy) begin
            unique case (st_q[i])
               WarpRun: begin
                  if (take_bar && (pick == WID_W'(i))) st_d[i] = WarpWait;
               end
               WarpWait: begin
                  if (bar_release || !bus.warp_active[i]) st_d[i] = WarpRun;
               end
               default: st_d[i] = WarpRun;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid_q <= 1'b0;
         issue_warp_q  <= '0;
         issue_inst_q  <= '0;
         last_q        <= WID_W'(WARP_NUM - 1);
         for (int unsigned i = 0; i < WARP_NUM; i++) begin
            st_q[i] <= WarpRun;
         end
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_warp_q  <= issue_warp_d;
         issue_inst_q  <= issue_inst_d;
         last_q        <= last_d;
         for (int unsigned i = 0; i < WARP_NUM; i++) begin
            st_q[i] <= st_d[i];
         end
      end
   end

   // No pops may escape while reset is held.
   assign bus.ibuf_caught = caught & {WARP_NUM{rst_n}};
   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_warp  = issue_warp_q;
   assign bus.issue_inst  = issue_inst_q;
   assign bus.bar_wait    = bar_wait;
endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Self-checking bench for gelato_warp_scheduler: directed scenarios plus randomized traffic
// against a cycle-level reference model written from the scheduling rules.
module tb_gelato_warp_scheduler;
   localparam int W     = 4;
   localparam int IW    = 64;
   localparam int OBS_W = W + 1 + 2 + IW + W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rdy   = 1'b0;

   gelato_warp_scheduler_if #(.WARP_NUM(W), .INST_W(IW)) bus ();

   gelato_warp_scheduler #(.WARP_NUM(W), .INST_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rdy   (rdy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state: contents of the issue slot, parked warps, last winner.
   bit          m_valid;
   int          m_warp;
   logic [IW-1:0] m_inst;
   bit [W-1:0]  m_bar;
   int          m_last;

   task automatic model_reset();
      m_valid = 0;
      m_warp  = 0;
      m_inst  = '0;
      m_bar   = '0;
      m_last  = W - 1;
   endtask

   function automatic int model_pick();
      for (int k = 1; k <= W; k++) begin
         int c;
         c = (m_last + k) % W;
         if (bus.warp_active[c] === 1'b1 && bus.ibuf_valid[c] === 1'b1 &&
             bus.warp_stall[c] === 1'b0 && !m_bar[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit model_load();
      return (rdy === 1'b1) && (!m_valid || bus.issue_ready === 1'b1);
   endfunction

   function automatic bit model_release();
      int parked, live;
      parked = 0;
      live   = 0;
      for (int i = 0; i < W; i++) begin
         if (bus.warp_active[i] === 1'b1) live++;
         if (bus.warp_active[i] === 1'b1 && m_bar[i]) parked++;
      end
      // Inactive parked warps are cleared anyway, so all-live-parked is the condition.
      return (m_bar != 0) && (parked == live);
   endfunction

   function automatic logic [OBS_W-1:0] model_expect();
      logic [W-1:0] c;
      int p;
      c = '0;
      p = model_pick();
      if (rst_n === 1'b1 && model_load() && p >= 0) c[p] = 1'b1;
      return {c, m_valid, 2'(m_warp), m_inst, m_bar};
   endfunction

   task automatic model_next();
      int p;
      bit [W-1:0] nb;
      if (rdy !== 1'b1) return;
      p  = model_pick();
      nb = model_release() ? '0 : m_bar;
      for (int i = 0; i < W; i++) if (bus.warp_active[i] !== 1'b1) nb[i] = 1'b0;
      if (model_load()) begin
         if (p >= 0) begin
            m_last = p;
            if (bus.ibuf_barrier[p] === 1'b1) begin
               nb[p]   = 1'b1;
               m_valid = 0;
            end else begin
               m_valid = 1;
               m_warp  = p;
               m_inst  = bus.ibuf_inst[p*IW +: IW];
            end
         end else begin
            m_valid = 0;
         end
      end
      m_bar = nb;
   endtask

   function automatic logic [OBS_W-1:0] observed();
      return {bus.ibuf_caught, bus.issue_valid, bus.issue_warp, bus.issue_inst, bus.bar_wait};
   endfunction

   task automatic drive(input logic [W-1:0] v, input logic [W-1:0] a, input logic [W-1:0] s,
                        input logic [W-1:0] b, input bit rd, input bit ir);
      bus.ibuf_valid   = v;
      bus.warp_active  = a;
      bus.warp_stall   = s;
      bus.ibuf_barrier = b;
      bus.issue_ready  = ir;
      rdy              = rd;
      for (int i = 0; i < W; i++) bus.ibuf_inst[i*IW +: IW] = {$urandom, $urandom};
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive('0, '0, '0, '0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      drive('1, '1, '0, '0, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (observed() !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs got %h want 0", observed());
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         drive('1, '1, '0, '0, 1'b1, 1'b1);
         @(negedge clk);
         tests_run += 2;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL rr_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         if (bus.ibuf_caught !== W'(1 << (k % W))) begin
            tests_failed++;
            $display("FAIL rr_caught cyc%0d got %b want %b", k, bus.ibuf_caught, W'(1 << (k % W)));
         end
         if (k > 0) begin
            tests_run++;
            if (bus.issue_warp !== 2'((k - 1) % W) || bus.issue_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL rr_issue_lag cyc%0d got v%b w%0d want v1 w%0d", k, bus.issue_valid,
                        bus.issue_warp, (k - 1) % W);
            end
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stall();
      int order [6] = '{0, 2, 0, 2, 0, 1};
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         if (k < 5) drive(4'b0101, '1, 4'b0010, '0, 1'b1, 1'b1);
         else       drive(4'b0111, '1, 4'b0000, '0, 1'b1, 1'b1);
         @(negedge clk);
         tests_run += 2;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL stall_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         if (bus.ibuf_caught !== W'(1 << order[k])) begin
            tests_failed++;
            $display("FAIL stall_order cyc%0d got %b want %b", k, bus.ibuf_caught,
                     W'(1 << order[k]));
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] inst0;
      apply_reset();
      inst0 = '0;
      for (int k = 0; k < 5; k++) begin
         drive('1, '1, '0, '0, 1'b1, (k == 0 || k == 4));
         if (k == 0) inst0 = bus.ibuf_inst[0 +: IW];
         @(negedge clk);
         tests_run += 2;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL bp_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         if (k == 0 && bus.ibuf_caught !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_first cyc%0d got %b want 0001", k, bus.ibuf_caught);
         end else if (k > 0 && k < 4 && (bus.ibuf_caught !== 4'b0000 || bus.issue_valid !== 1'b1 ||
                      bus.issue_warp !== 2'd0 || bus.issue_inst !== inst0)) begin
            tests_failed++;
            $display("FAIL bp_hold cyc%0d got c%b v%b w%0d i%h want c0000 v1 w0 i%h", k,
                     bus.ibuf_caught, bus.issue_valid, bus.issue_warp, bus.issue_inst, inst0);
         end else if (k == 4 && bus.ibuf_caught !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_resume cyc%0d got %b want 0010", k, bus.ibuf_caught);
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_barrier();
      logic [W-1:0] v_t  [7] = '{4'b0001, 4'b0100, 4'b0010, 4'b0111, 4'b1000, 4'b0000, 4'b0000};
      logic [W-1:0] b_t  [7] = '{4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      logic [W-1:0] c_t  [7] = '{4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      logic [W-1:0] bw_t [7] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111, 4'b0111, 4'b1111, 4'b0000};
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         drive(v_t[k], '1, '0, b_t[k], 1'b1, 1'b1);
         @(negedge clk);
         tests_run += 2;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL bar_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         if (bus.ibuf_caught !== c_t[k] || bus.bar_wait !== bw_t[k] || bus.issue_valid !== 1'b0)
         begin
            tests_failed++;
            $display("FAIL bar_seq cyc%0d got c%b bw%b v%b want c%b bw%b v0", k, bus.ibuf_caught,
                     bus.bar_wait, bus.issue_valid, c_t[k], bw_t[k]);
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_deactivate();
      logic [W-1:0] v_t  [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [W-1:0] a_t  [5] = '{4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0011};
      logic [W-1:0] bw_t [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0000};
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         drive(v_t[k], a_t[k], '0, v_t[k], 1'b1, 1'b1);
         @(negedge clk);
         tests_run += 2;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL deact_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         if (bus.bar_wait !== bw_t[k]) begin
            tests_failed++;
            $display("FAIL deact_barwait cyc%0d got %b want %b", k, bus.bar_wait, bw_t[k]);
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] v_t [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
      logic [W-1:0] b_t [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         drive(v_t[k], '1, '0, b_t[k], 1'b1, (k < 3));
         @(negedge clk);
         tests_run++;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL rstmid_model cyc%0d got %h want %h", k, observed(), model_expect());
         end
         model_next();
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (bus.issue_valid !== 1'b1 || bus.bar_wait !== 4'b0011) begin
         tests_failed++;
         $display("FAIL rstmid_setup got v%b bw%b want v1 bw0011", bus.issue_valid, bus.bar_wait);
      end
      drive('1, '1, '0, '0, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (observed() !== '0) begin
         tests_failed++;
         $display("FAIL rstmid_zero got %h want 0", observed());
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive('1, '1, '0, '0, 1'b1, 1'b1);
      @(negedge clk);
      tests_run += 2;
      if (observed() !== model_expect()) begin
         tests_failed++;
         $display("FAIL rstmid_after got %h want %h", observed(), model_expect());
      end
      if (bus.ibuf_caught !== 4'b0001) begin
         tests_failed++;
         $display("FAIL rstmid_first got %b want 0001", bus.ibuf_caught);
      end
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [W-1:0] v, a, s, b;
      apply_reset();
      for (int k = 0; k < 800; k++) begin
         for (int i = 0; i < W; i++) begin
            v[i] = ($urandom_range(3) != 0);
            a[i] = ($urandom_range(11) != 0);
            s[i] = ($urandom_range(3) == 0);
            b[i] = ($urandom_range(4) == 0);
         end
         drive(v, a, s, b, ($urandom_range(7) != 0), ($urandom_range(3) != 0));
         @(negedge clk);
         tests_run++;
         if (observed() !== model_expect()) begin
            tests_failed++;
            $display("FAIL random cyc%0d got %h want %h", k, observed(), model_expect());
         end
         model_next();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_stall();
      test_backpressure();
      test_barrier();
      test_deactivate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
